dp_pipe: RTL and testbench
==========================

# dp_pipe

Parametrised, two-stage pipelined successor to the single-cycle processing unit: an NREG × M register file, ALU, shifter, and the B/F/D operand and result muxes, fed by a valid/ready micro-op interface. Each micro-op is executed in the EX stage and written back one cycle later in the WB stage. Read-after-write hazards are handled by a bypass path, or by stalling when the bypass is compiled out. The block sits between the control sequencer and the memory interface: it drives Address_out and Data_out and returns condition Tags.

## Interface
- M, 8, datapath width in bits (≥4)
- NREG, 4, register count; power of two ≥2; RW = $clog2(NREG)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  micro-op present
- op_ready  out  1  micro-op accepted when op_valid && op_ready at rising clk
- A_sel, B_sel, Dest_sel  in  RW each  source A, source B, destination register
- G_sel  in  4  ALU function
- H_sel  in  2  shifter function
- MB_sel  in  1  0 = register B, 1 = Cons_IN
- MF_sel  in  1  0 = ALU, 1 = shifter
- MD_sel  in  1  0 = function result F, 1 = Data_IN
- Load_en  in  1  write result to Dest_sel
- Cons_IN, Data_IN  in  M each  constant and external data
- Address_out  out  M  registered operand A of the last accepted op
- Data_out  out  M  registered operand B (after MB mux) of the last accepted op
- Reg_in  out  M  value in WB stage (write data)
- wb_en  out  1  WB stage performs a register write this cycle
- Tags  out  4  {V,C,N,Z}, registered

## Operation
- ALU (G_sel), with carry out C taken from bit M:
  - 0000 A
  - 0001 A+1
  - 0010 A+B
  - 0011 A+B+1
  - 0100 A+~B
  - 0101 A+~B+1
  - 0110 A−1 (A+all-ones)
  - 0111 A
  - 1000 A&B
  - 1010 A|B
  - 1100 A^B
  - 1110 ~A
  - odd codes ≥1001 alias the even code below them
- Arithmetic is modulo 2^M. V = signed overflow of the addition actually performed.
- Logic codes force C = 0 and V = 0.
- Shifter operates on B (after MB mux):
  - 00 B
  - 01 B<<1, zero fill, C = B[M-1]
  - 10 B>>1, zero fill, C = B[0]
  - 11 all zeros, C = 0
  - V = 0 for all shifter functions
- F = MF_sel ? shifter : ALU.
- Result = MD_sel ? Data_IN : F.
- Tags: Z = (F == 0), N = F[M-1], plus C and V from the selected unit.
  - Updated on accept only when MD_sel = 0; otherwise held.
- EX/WB register, loaded on accept: Result, Dest_sel, Load_en. Address_out and Data_out are loaded at the same edge.
  - With no accept, the stage empties: wb_en = 0, data held.
- WB: when wb_en = 1, the register file is written at the next rising clk. Reg_in = staged Result.
- Register-file reads are combinational and return the pre-write value.
- Hazard: a pending WB write with Dest_sel matching A_sel, or matching B_sel with MB_sel = 0.
- Back-to-back writes to the same register: the later op wins. No write is lost or reordered.
- Reset (asynchronous, any time) clears:
  - all registers, Address_out, Data_out, Reg_in, Tags, and wb_en to 0
  - any pending write, which is discarded
- op_ready = 0 while rst_n is low.

## Timing
- Accept at edge k: Address_out, Data_out, Tags, Reg_in, and wb_en are valid after edge k. The register holds the value after edge k+1.
- Throughput: one op per cycle with the bypass; op_ready is combinational from the op inputs and the WB state.
- op_valid may drop without acceptance; no state changes.
- The first cycle after rst_n deasserts: op_ready = 1 (pipeline empty).

## Configuration
- BYPASS_EN defined:
  - hazard operands are taken from the staged Result
  - op_ready = 1 whenever out of reset
- BYPASS_EN undefined:
  - op_ready = 0 for exactly one cycle on a hazard, while the write completes
  - the op is accepted the following cycle with the updated register value
  - results are identical; only the cycle count differs

## Test plan
- Reset: hold rst_n low mid-write (Load R1 = 0x55 accepted, reset before WB) -> all outputs 0, op_ready = 0; after release R1 reads 0 and op_ready = 1.
- Load R1 = 4, R2 = 8 back-to-back (MD_sel = 1), then A = R1, B = R2, G = 0010, Dest = R3:
  - Reg_in = 12, Tags = 0000
  - BYPASS_EN: 3 consecutive accepts
  - without BYPASS_EN: op_ready low 1 cycle before op 3
- R1 = 4, R2 = 8, G = 0101 -> F = 0xFC, Tags {V,C,N,Z} = 0010.
- R1 = 0x7F, G = 0001 -> 0x80, Tags = 1010. R1 = 0xFF, G = 0001 -> 0x00, Tags = 0101.
- Shifter, MF_sel = 1, B = 0x81: H = 01 -> 0x02, C = 1; H = 10 -> 0x40, C = 1; H = 11 -> 0x00, Z = 1.
- MB_sel = 1, Cons_IN = 50, A = R1 = 4, G = 0010 -> Reg_in = 54, Data_out = 50. An op with Load_en = 0 leaves the destination register unchanged.

Source files
------------

// File: rtl/dp_pipe.sv
// -----------------------------------------------------------------------------
// dp_pipe : two-stage (EX / WB) pipelined datapath.
//
// Executes one micro-op per accepted handshake in the EX stage and writes the
// result back to an NREG x M register file one cycle later in the WB stage.
// Contains the register file, the ALU, the shifter, and the B (operand),
// F (function) and D (destination data) muxes.
//
// Compile-time option:
//   BYPASS_EN  defined   -> read-after-write hazards are resolved by forwarding
//                           the staged WB result; op_ready is 1 out of reset.
//              undefined -> a hazard drops op_ready for one cycle while the
//                           pending write completes, then the op is accepted.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   op_valid / op_ready     micro-op handshake (op_ready is combinational)
//   A_sel, B_sel, Dest_sel  source A, source B, destination register
//   G_sel, H_sel            ALU function, shifter function
//   MB_sel, MF_sel, MD_sel  B mux (Cons_IN), F mux (shifter), D mux (Data_IN)
//   Load_en                 write the result to Dest_sel
//   Cons_IN, Data_IN        constant operand, external data
//   Address_out, Data_out   registered operands A and B of the last accepted op
//   Reg_in, wb_en           WB-stage write data and write enable
//   Tags                    registered {V,C,N,Z}
// -----------------------------------------------------------------------------
module dp_pipe #(
  parameter  int M    = 8,
  parameter  int NREG = 4,
  localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [RW-1:0] A_sel,
  input  logic [RW-1:0] B_sel,
  input  logic [RW-1:0] Dest_sel,
  input  logic [3:0]    G_sel,
  input  logic [1:0]    H_sel,
  input  logic          MB_sel,
  input  logic          MF_sel,
  input  logic          MD_sel,
  input  logic          Load_en,
  input  logic [M-1:0]  Cons_IN,
  input  logic [M-1:0]  Data_IN,
  output logic [M-1:0]  Address_out,
  output logic [M-1:0]  Data_out,
  output logic [M-1:0]  Reg_in,
  output logic          wb_en,
  output logic [3:0]    Tags
);

  // Architectural state and EX/WB pipeline register
  logic [M-1:0]  rf_q [NREG];
  logic [M-1:0]  rf_d [NREG];
  logic [M-1:0]  address_q, address_d;
  logic [M-1:0]  data_q, data_d;
  logic [M-1:0]  reg_in_q, reg_in_d;
  logic [RW-1:0] wb_dest_q, wb_dest_d;
  logic          wb_en_q, wb_en_d;
  logic [3:0]    tags_q, tags_d;

  // Operand path
  logic [M-1:0]  a_rf_s, b_rf_s;
  logic          hazard_a_s, hazard_b_s;
  logic [M-1:0]  a_op_s, b_reg_s, b_op_s;
  logic          accept_s;

  // Function units
  logic [M-1:0]  add_y_s;
  logic          add_cin_s;
  logic [M:0]    sum_s;
  logic          is_logic_s;
  logic [M-1:0]  logic_res_s;
  logic [M-1:0]  alu_f_s;
  logic          alu_c_s, alu_v_s;
  logic [M-1:0]  sh_f_s;
  logic          sh_c_s;
  logic [M-1:0]  f_s;
  logic          f_c_s, f_v_s;
  logic [M-1:0]  result_s;

  // Register-file read, hazard detection, forwarding and handshake
  always_comb begin
    a_rf_s     = rf_q[A_sel];
    b_rf_s     = rf_q[B_sel];
    // B only conflicts when it actually comes from the register file
    hazard_a_s = wb_en_q && (wb_dest_q == A_sel);
    hazard_b_s = wb_en_q && (wb_dest_q == B_sel) && !MB_sel;
`ifdef BYPASS_EN
    if (hazard_a_s) begin
      a_op_s = reg_in_q;
    end else begin
      a_op_s = a_rf_s;
    end
    if (hazard_b_s) begin
      b_reg_s = reg_in_q;
    end else begin
      b_reg_s = b_rf_s;
    end
    op_ready = rst_n;
`else
    a_op_s   = a_rf_s;
    b_reg_s  = b_rf_s;
    // Hold off for the one cycle it takes the pending write to land
    op_ready = rst_n && !(hazard_a_s || hazard_b_s);
`endif
    if (MB_sel) begin
      b_op_s = Cons_IN;
    end else begin
      b_op_s = b_reg_s;
    end
    accept_s = op_valid && op_ready;
  end

  // ALU: every arithmetic code is A + Y + cin; logic codes bypass the adder
  always_comb begin
    add_y_s     = {M{1'b0}};
    add_cin_s   = 1'b0;
    is_logic_s  = 1'b0;
    logic_res_s = {M{1'b0}};
    case (G_sel)
      4'b0000: begin add_y_s = {M{1'b0}}; add_cin_s = 1'b0; end
      4'b0001: begin add_y_s = {M{1'b0}}; add_cin_s = 1'b1; end
      4'b0010: begin add_y_s = b_op_s;    add_cin_s = 1'b0; end
      4'b0011: begin add_y_s = b_op_s;    add_cin_s = 1'b1; end
      4'b0100: begin add_y_s = ~b_op_s;   add_cin_s = 1'b0; end
      4'b0101: begin add_y_s = ~b_op_s;   add_cin_s = 1'b1; end
      4'b0110: begin add_y_s = {M{1'b1}}; add_cin_s = 1'b0; end
      4'b0111: begin add_y_s = {M{1'b0}}; add_cin_s = 1'b0; end
      4'b1000, 4'b1001: begin is_logic_s = 1'b1; logic_res_s = a_op_s & b_op_s; end
      4'b1010, 4'b1011: begin is_logic_s = 1'b1; logic_res_s = a_op_s | b_op_s; end
      4'b1100, 4'b1101: begin is_logic_s = 1'b1; logic_res_s = a_op_s ^ b_op_s; end
      4'b1110, 4'b1111: begin is_logic_s = 1'b1; logic_res_s = ~a_op_s; end
      default: begin is_logic_s = 1'b0; logic_res_s = {M{1'b0}}; end
    endcase
  end

  // Adder, flags and ALU result selection
  always_comb begin
    sum_s = {1'b0, a_op_s} + {1'b0, add_y_s} + {{M{1'b0}}, add_cin_s};
    if (is_logic_s) begin
      alu_f_s = logic_res_s;
      alu_c_s = 1'b0;
      alu_v_s = 1'b0;
    end else begin
      alu_f_s = sum_s[M-1:0];
      alu_c_s = sum_s[M];
      // Signed overflow: like-signed addends producing a differently-signed sum
      alu_v_s = (a_op_s[M-1] == add_y_s[M-1]) && (sum_s[M-1] != a_op_s[M-1]);
    end
  end

  // Shifter on the post-MB-mux B operand
  always_comb begin
    case (H_sel)
      2'b00:   begin sh_f_s = b_op_s;                    sh_c_s = 1'b0;        end
      2'b01:   begin sh_f_s = {b_op_s[M-2:0], 1'b0};     sh_c_s = b_op_s[M-1]; end
      2'b10:   begin sh_f_s = {1'b0, b_op_s[M-1:1]};     sh_c_s = b_op_s[0];   end
      default: begin sh_f_s = {M{1'b0}};                 sh_c_s = 1'b0;        end
    endcase
  end

  // F and D muxes
  always_comb begin
    if (MF_sel) begin
      f_s   = sh_f_s;
      f_c_s = sh_c_s;
      f_v_s = 1'b0;
    end else begin
      f_s   = alu_f_s;
      f_c_s = alu_c_s;
      f_v_s = alu_v_s;
    end
    if (MD_sel) begin
      result_s = Data_IN;
    end else begin
      result_s = f_s;
    end
  end

  // Next-state: WB write into the register file, EX/WB load on accept
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (wb_en_q && (wb_dest_q == RW'(i))) begin
        rf_d[i] = reg_in_q;
      end else begin
        rf_d[i] = rf_q[i];
      end
    end
    address_d = address_q;
    data_d    = data_q;
    reg_in_d  = reg_in_q;
    wb_dest_d = wb_dest_q;
    wb_en_d   = 1'b0;
    tags_d    = tags_q;
    if (accept_s) begin
      address_d = a_op_s;
      data_d    = b_op_s;
      reg_in_d  = result_s;
      wb_dest_d = Dest_sel;
      wb_en_d   = Load_en;
      // Tags describe F, so an op that loads Data_IN leaves them untouched
      if (!MD_sel) begin
        tags_d = {f_v_s, f_c_s, f_s[M-1], (f_s == {M{1'b0}})};
      end else begin
        tags_d = tags_q;
      end
    end else begin
      // Bubble: the stage empties but keeps its data visible
      wb_en_d = 1'b0;
    end
  end

  // State registers; reset also discards any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= {M{1'b0}};
      end
      address_q <= {M{1'b0}};
      data_q    <= {M{1'b0}};
      reg_in_q  <= {M{1'b0}};
      wb_dest_q <= {RW{1'b0}};
      wb_en_q   <= 1'b0;
      tags_q    <= 4'b0000;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
      address_q <= address_d;
      data_q    <= data_d;
      reg_in_q  <= reg_in_d;
      wb_dest_q <= wb_dest_d;
      wb_en_q   <= wb_en_d;
      tags_q    <= tags_d;
    end
  end

  assign Address_out = address_q;
  assign Data_out    = data_q;
  assign Reg_in      = reg_in_q;
  assign wb_en       = wb_en_q;
  assign Tags        = tags_q;

endmodule

// File: tb/tb_dp_pipe.sv
// -----------------------------------------------------------------------------
// tb_dp_pipe : self-checking bench for dp_pipe.
// A program-order model (register values updated the moment an op is accepted)
// predicts every registered output and op_ready each cycle; a few literal
// expectations from hand-worked examples pin the model.
// -----------------------------------------------------------------------------
module tb_dp_pipe;
  localparam int M    = 8;
  localparam int NREG = 4;
  localparam int RW   = 2;
  localparam int unsigned FULL = 32'd1 << M;
  localparam int unsigned MASK = FULL - 32'd1;
  localparam int unsigned HALF = 32'd1 << (M - 1);
`ifdef BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic [RW-1:0] A_sel, B_sel, Dest_sel;
  logic [3:0]    G_sel;
  logic [1:0]    H_sel;
  logic          MB_sel, MF_sel, MD_sel, Load_en;
  logic [M-1:0]  Cons_IN, Data_IN;
  logic [M-1:0]  Address_out, Data_out, Reg_in;
  logic          wb_en;
  logic [3:0]    Tags;

  always #5 clk = ~clk;

  dp_pipe #(.M(M), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .A_sel(A_sel), .B_sel(B_sel), .Dest_sel(Dest_sel), .G_sel(G_sel),
    .H_sel(H_sel), .MB_sel(MB_sel), .MF_sel(MF_sel), .MD_sel(MD_sel),
    .Load_en(Load_en), .Cons_IN(Cons_IN), .Data_IN(Data_IN),
    .Address_out(Address_out), .Data_out(Data_out), .Reg_in(Reg_in),
    .wb_en(wb_en), .Tags(Tags)
  );

  // Model state (owned by the checker process)
  int unsigned arch [NREG];
  int unsigned m_addr, m_data, m_regin, m_tags;
  bit          m_wb, pend_v, exp_ready;
  int unsigned pend_dest;
  int          n_pass = 0;
  int          n_chk  = 0;

  // Literal expectations posted by the driver
  int          lit_seq = 0;
  int          lit_mask;
  int unsigned lit_regin, lit_tags, lit_data, lit_addr;
  int          lit_stall_act, lit_stall_exp;
  int          n_timeout = 0;

  function automatic int sgn(input int unsigned x);
    return (x >= HALF) ? (int'(x) - int'(FULL)) : int'(x);
  endfunction

  // Behavioural function: plain integer arithmetic on the rule table
  function automatic void model_f(input int unsigned a, input int unsigned b,
                                  input int unsigned g, input int unsigned h,
                                  input bit mf, output int unsigned f,
                                  output int unsigned c, output int unsigned v);
    int unsigned y, cin, tot;
    int st;
    f = 0; c = 0; v = 0; y = 0; cin = 0;
    if (mf) begin
      case (h)
        0: f = b;
        1: begin f = (b << 1) & MASK; c = (b >> (M - 1)) & 1; end
        2: begin f = b >> 1; c = b & 1; end
        default: f = 0;
      endcase
    end else if (g >= 8) begin
      case (g & 32'hE)
        8:  f = a & b;
        10: f = a | b;
        12: f = a ^ b;
        default: f = (~a) & MASK;
      endcase
    end else begin
      case (g)
        1: cin = 1;
        2: y = b;
        3: begin y = b; cin = 1; end
        4: y = (~b) & MASK;
        5: begin y = (~b) & MASK; cin = 1; end
        6: y = MASK;
        default: y = 0;
      endcase
      tot = a + y + cin;
      f = tot & MASK;
      c = (tot >= FULL) ? 1 : 0;
      st = sgn(a) + sgn(y) + int'(cin);
      v = (st > int'(HALF) - 1 || st < -int'(HALF)) ? 1 : 0;
    end
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Checker: advance the model at each edge, compare away from the edge
  initial begin
    int unsigned a, b, f, c, v, res;
    int seen = 0;
    exp_ready = 1'b0;
    forever begin
      @(posedge clk);
      if (rst_n && op_valid && exp_ready) begin
        a = arch[A_sel];
        b = MB_sel ? 32'(Cons_IN) : arch[B_sel];
        model_f(a, b, 32'(G_sel), 32'(H_sel), MF_sel, f, c, v);
        res = MD_sel ? 32'(Data_IN) : f;
        m_addr = a; m_data = b; m_regin = res; m_wb = Load_en;
        if (!MD_sel) m_tags = (v << 3) | (c << 2) | (((f >> (M - 1)) & 1) << 1) | ((f == 0) ? 1 : 0);
        if (Load_en) arch[Dest_sel] = res;
        pend_v = Load_en; pend_dest = 32'(Dest_sel);
      end else if (rst_n) begin
        m_wb = 1'b0; pend_v = 1'b0;
      end
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < NREG; i++) arch[i] = 0;
        m_addr = 0; m_data = 0; m_regin = 0; m_tags = 0; m_wb = 0; pend_v = 0;
        exp_ready = 1'b0;
      end else if (BYP) begin
        exp_ready = 1'b1;
      end else begin
        exp_ready = !(pend_v && (pend_dest == 32'(A_sel) ||
                                 (pend_dest == 32'(B_sel) && !MB_sel)));
      end
      chk("op_ready", 32'(op_ready), 32'(exp_ready));
      chk("Address_out", 32'(Address_out), m_addr);
      chk("Data_out", 32'(Data_out), m_data);
      chk("Reg_in", 32'(Reg_in), m_regin);
      chk("wb_en", 32'(wb_en), 32'(m_wb));
      chk("Tags", 32'(Tags), m_tags);
      if (lit_seq != seen) begin
        seen = lit_seq;
        if (lit_mask[0]) chk("lit_Reg_in", 32'(Reg_in), lit_regin);
        if (lit_mask[1]) chk("lit_Tags", 32'(Tags), lit_tags);
        if (lit_mask[2]) chk("lit_Data_out", 32'(Data_out), lit_data);
        if (lit_mask[3]) chk("lit_Address_out", 32'(Address_out), lit_addr);
        if (lit_mask[4]) chk("lit_stall_cycles", lit_stall_act, lit_stall_exp);
      end
    end
  end

  // Present one op and hold it until accepted; returns stall cycles seen
  task automatic do_op(input int a, input int b, input int d, input int g, input int h,
                       input bit mb, input bit mf, input bit md, input bit ld,
                       input int cons, input int data, output int stalls);
    logic r;
    A_sel = RW'(a); B_sel = RW'(b); Dest_sel = RW'(d);
    G_sel = 4'(g); H_sel = 2'(h);
    MB_sel = mb; MF_sel = mf; MD_sel = md; Load_en = ld;
    Cons_IN = M'(cons); Data_IN = M'(data);
    op_valid = 1'b1;
    stalls = 0;
    r = 1'b0;
    for (int i = 0; i < 4 && !r; i++) begin
      @(negedge clk);
      r = op_ready;
      @(posedge clk);
      #1;
      if (!r) stalls++;
    end
    if (!r) begin
      n_timeout++;
      $display("FAIL accept_timeout: op not accepted within 4 cycles at %0t", $time);
    end
    op_valid = 1'b0;
  endtask

  task automatic expect_lit(input int mask, input int unsigned regin, input int unsigned tg,
                            input int unsigned data, input int unsigned addr,
                            input int st_act, input int st_exp);
    lit_mask = mask; lit_regin = regin; lit_tags = tg; lit_data = data; lit_addr = addr;
    lit_stall_act = st_act; lit_stall_exp = st_exp;
    lit_seq++;
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    int s, s1, s2;
    rst_n = 1'b0; op_valid = 1'b0;
    A_sel = '0; B_sel = '0; Dest_sel = '0; G_sel = 4'd0; H_sel = 2'd0;
    MB_sel = 1'b0; MF_sel = 1'b0; MD_sel = 1'b0; Load_en = 1'b0;
    Cons_IN = '0; Data_IN = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Reset while a write to R1 is still pending: it must be discarded
    do_op(0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h55, s);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    do_op(1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, s);
    expect_lit(8, 0, 0, 0, 0, 0, 0);

    // R1 = 4, R2 = 8 back-to-back, then R3 = R1 + R2
    do_op(0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 4, s1);
    do_op(0, 0, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8, s2);
    expect_lit(16, 0, 0, 0, 0, s1 + s2, 0);
    do_op(1, 2, 3, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, s);
    expect_lit(1 | 2 | 16, 12, 0, 0, 0, s, BYP ? 0 : 1);

    // R1 - R2 = 0xFC
    do_op(1, 2, 3, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, s);
    expect_lit(1 | 2, 8'hFC, 4'b0010, 0, 0, 0, 0);

    // Increment overflow and wrap-around
    do_op(0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'h7F, s);
    do_op(1, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, s);
    expect_lit(1 | 2, 8'h80, 4'b1010, 0, 0, 0, 0);
    do_op(0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8'hFF, s);
    do_op(1, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, s);
    expect_lit(1 | 2, 8'h00, 4'b0101, 0, 0, 0, 0);

    // Shifter on B = 0x81
    do_op(0, 0, 3, 0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 0, s);
    expect_lit(1 | 2 | 4, 8'h02, 4'b0100, 8'h81, 0, 0, 0);
    do_op(0, 0, 3, 0, 2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 0, s);
    expect_lit(1 | 2, 8'h40, 4'b0100, 0, 0, 0, 0);
    do_op(0, 0, 3, 0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 0, s);
    expect_lit(1 | 2, 8'h00, 4'b0001, 0, 0, 0, 0);

    // Constant operand, then a non-loading op must leave R2 = 8
    do_op(0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 4, s);
    do_op(1, 0, 3, 2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 50, 0, s);
    expect_lit(1 | 4 | 8, 54, 0, 50, 4, 0, 0);
    do_op(1, 0, 2, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, s);
    do_op(2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, s);
    expect_lit(8, 0, 0, 0, 8, 0, 0);

    // Randomised traffic with idle gaps
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      do_op(int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
            int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), s);
    end
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk + n_timeout);
    $finish;
  end
endmodule
